// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one byte-enabled write port,
// optional hardwired-zero entry 0, optional write-to-read bypass and a bulk-clear engine.
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     r1_addr,
    input  logic [ADDR_W-1:0]     r2_addr,
    output logic [DATA_W-1:0]     r1_dout,
    output logic [DATA_W-1:0]     r2_dout,
    input  logic [ADDR_W-1:0]     r3_addr,
    input  logic [DATA_W-1:0]     r3_din,
    input  logic                  r3_wr,
    input  logic [DATA_W/8-1:0]   r3_be,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  dbg_clr_state
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   w_clr_ptr_nxt;
    logic                w_clr_en;
    logic                w_busy;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_r1_dout;
    logic [DATA_W-1:0]   r_r2_dout;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_r1_nxt;
    logic [DATA_W-1:0]   w_r2_nxt;
    logic                w_wr_ok;
    logic                w_last;

    // Clear FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    assign w_last = (r_clr_ptr == {ADDR_W{1'b1}});

    // Clear FSM: next state; clr_req is only looked at in IDLE
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            S_CLEAR: begin
                if (w_last) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_ptr_nxt = '0;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        w_busy   = 1'b0;
        w_clr_en = 1'b0;
        if (r_state == S_CLEAR) begin
            w_busy   = 1'b1;
            w_clr_en = 1'b1;
        end
    end

    assign w_wr_ok = r3_wr && !w_busy && !((ZERO_REG != 0) && (r3_addr == '0));

    always_comb begin
        w_merged = r_mem[r3_addr];
        for (int b = 0; b < NB; b++) begin
            if (r3_be[b]) begin
                w_merged[8*b +: 8] = r3_din[8*b +: 8];
            end
        end
    end

    // Read mux: zero entry wins over bypass, bypass wins over stored data
    always_comb begin
        w_r1_nxt = r_mem[r1_addr];
        w_r2_nxt = r_mem[r2_addr];
        if ((BYPASS != 0) && w_wr_ok && (r3_addr == r1_addr)) begin
            w_r1_nxt = w_merged;
        end
        if ((BYPASS != 0) && w_wr_ok && (r3_addr == r2_addr)) begin
            w_r2_nxt = w_merged;
        end
        if ((ZERO_REG != 0) && (r1_addr == '0)) begin
            w_r1_nxt = '0;
        end
        if ((ZERO_REG != 0) && (r2_addr == '0)) begin
            w_r2_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_ok) begin
                r_mem[r3_addr] <= w_merged;
            end
            if (w_clr_en) begin
                r_mem[r_clr_ptr] <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r1_dout <= '0;
            r_r2_dout <= '0;
        end else begin
            r_r1_dout <= w_r1_nxt;
            r_r2_dout <= w_r2_nxt;
        end
    end

    assign r1_dout       = r_r1_dout;
    assign r2_dout       = r_r2_dout;
    assign busy          = w_busy;
    assign dbg_clr_state = r_state;

endmodule
